regfile_sb: RTL

Parametrised multi-port register file with an integrated scoreboard, the next-generation datapath register bank for the processor. It provides NRD combinational read ports, one clocked write port, optional write-to-read bypass and a busy bit per register. The busy bit lets the control unit issue multicycle operations and stall dependent instructions until writeback. Register 0 is hardwired to zero and is never busy.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the regfile_sb register bank.
package regfile_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NRD   = 2;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);

    // Widest busy vector the popcount helper accepts; callers zero-extend into it.
    localparam int POP_MAX   = 256;

    typedef logic [DEF_AW-1:0] addr_t;

    function automatic logic [31:0] popcount(input logic [POP_MAX-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, issue wins on a collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int NBW  = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss,
    input  logic [AW-1:0]    ia,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    output logic [DEPTH-1:0] busy,
    output logic             idle,
    output logic [NBW-1:0]   nbusy
);

    logic [DEPTH-1:0]   busy_reg;
    logic [DEPTH-1:0]   busy_next;
    logic [POP_MAX-1:0] pop_vec;
    logic [NBW-1:0]     nbusy_reg;
    logic [NBW-1:0]     nbusy_next;
    logic               idle_reg;
    logic               idle_next;

    // Clear first, then set, so a same-edge issue keeps ownership of the register.
    always_comb begin
        busy_next = busy_reg;
        if (we && wa != '0) begin
            busy_next[wa] = 1'b0;
        end
        if (iss && ia != '0) begin
            busy_next[ia] = 1'b1;
        end
    end

    always_comb begin
        pop_vec = '0;
        pop_vec[DEPTH-1:0] = busy_next;
    end

    assign nbusy_next = NBW'(popcount(pop_vec));
    assign idle_next  = (busy_next == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg  <= '0;
            nbusy_reg <= '0;
            idle_reg  <= 1'b1;
        end else begin
            busy_reg  <= busy_next;
            nbusy_reg <= nbusy_next;
            idle_reg  <= idle_next;
        end
    end

    assign busy  = busy_reg;
    assign nbusy = nbusy_reg;
    assign idle  = idle_reg;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard and optional write bypass.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NRD    = DEF_NRD,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rbusy,
    input  logic                 iss,
    input  logic [AW-1:0]        ia,
    output logic                 idle,
    output logic [AW:0]          nbusy
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] busy;

    // Entry 0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we && wa != '0) begin
            mem_reg[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .iss   (iss),
        .ia    (ia),
        .we    (we),
        .wa    (wa),
        .busy  (busy),
        .idle  (idle),
        .nbusy (nbusy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]    addr;
            logic [WIDTH-1:0] data;
            logic             hazard;

            assign addr = ra[gi*AW +: AW];

            // A same-cycle writeback resolves the hazard, so the forwarded value is never busy.
            always_comb begin
                data   = '0;
                hazard = 1'b0;
                if (addr != '0) begin
                    if (BYPASS != 0 && we && wa == addr) begin
                        data = wd;
                    end else begin
                        data   = mem_reg[addr];
                        hazard = busy[addr];
                    end
                end
            end

            assign rd[gi*WIDTH +: WIDTH] = data;
            assign rbusy[gi]             = hazard;
        end
    endgenerate

endmodule
